// File: rtl/shift_arb_ctrl_pkg.sv
// shift_arb_ctrl_pkg: shared widths, shift opcodes and controller states
package shift_arb_ctrl_pkg;
    localparam int N = 32;
    localparam int S = 5;
    localparam int O = 3;
    localparam logic [2:0] SHLEFTLOG = 3'b000;
    localparam logic [2:0] SHLEFTART = 3'b001;
    localparam logic [2:0] SHRGHTLOG = 3'b010;
    localparam logic [2:0] SHRGHTART = 3'b011;
    localparam int OP_ILLEGAL_BIT = 2;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/shift_arb_ctrl_rr_picker.sv
// rr_picker: round-robin arbiter, nearest requester at or after ptr wins
module rr_picker #(
    parameter int NREQ = 4,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);
    // scan offsets far to near so the closest active requester after ptr is kept
    always_comb begin
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            idx = req[ptr + IW'(k)] ? ptr + IW'(k) : idx;
        any = |req;
        grant = any ? NREQ'(1) << idx : '0;
    end
endmodule

// File: rtl/shift_arb_ctrl.sv
// shift_arb_ctrl: round-robin front end sharing one registered shift unit among NREQ requesters
module shift_arb_ctrl #(
    parameter int NREQ = 4,
    parameter int N    = shift_arb_ctrl_pkg::N,
    parameter int S    = shift_arb_ctrl_pkg::S,
    parameter int O    = shift_arb_ctrl_pkg::O
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*N-1:0]       req_data,
    input  logic [NREQ*S-1:0]       req_shamt,
    input  logic [NREQ*O-1:0]       req_op,
    output logic [N-1:0]            alu_in,
    output logic [S-1:0]            alu_shift,
    output logic [O-1:0]            alu_op,
    output logic                    alu_enable,
    input  logic [N:0]              alu_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [N:0]              rsp_data,
    output logic                    rsp_err,
    output logic                    busy
);
    import shift_arb_ctrl_pkg::*;

    localparam int IW = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [N-1:0]    data_q, data_d;
    logic [S-1:0]    shamt_q, shamt_d;
    logic [O-1:0]    op_q, op_d;
    logic [IW-1:0]   id_q, id_d, rr_ptr_q, rr_ptr_d, pick_idx;
    logic [N:0]      rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d, pick_any;
    logic [NREQ-1:0] pick_grant;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // grant and latch in IDLE, launch or reject in ISSUE, capture in WAIT, hold in RESP
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        shamt_d    = shamt_q;
        op_d       = op_q;
        id_d       = id_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: if (pick_any) begin
                data_d   = req_data[pick_idx*N +: N];
                shamt_d  = req_shamt[pick_idx*S +: S];
                op_d     = req_op[pick_idx*O +: O];
                id_d     = pick_idx;
                rr_ptr_d = pick_idx + IW'(1);
                state_d  = ISSUE;
            end
            ISSUE: begin
                rsp_err_d  = op_q[OP_ILLEGAL_BIT];
                rsp_data_d = '0;
                state_d    = op_q[OP_ILLEGAL_BIT] ? RESP : WAIT;
            end
            WAIT: begin
                rsp_data_d = alu_result;
                state_d    = RESP;
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // state and latched transaction; reset abandons anything in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            shamt_q    <= '0;
            op_q       <= '0;
            id_q       <= '0;
            rr_ptr_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            shamt_q    <= shamt_d;
            op_q       <= op_d;
            id_q       <= id_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign req_ready  = (state_q == IDLE && !reset) ? pick_grant : '0;
    assign alu_in     = data_q;
    assign alu_shift  = shamt_q;
    assign alu_op     = op_q;
    assign alu_enable = state_q == ISSUE && !op_q[OP_ILLEGAL_BIT];
    assign rsp_valid  = state_q == RESP;
    assign rsp_id     = id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = state_q != IDLE;
endmodule

// File: doc/shift_arb_ctrl.md
SHIFT_ARB_CTRL -- requirements
Module: shift_arb_ctrl

Interface
REQ-001 Parameter NREQ, 4, number of requesters sharing one shift unit (power of 2, 2..8).
REQ-002 Parameter N, 32, operand width; result width N+1.
REQ-003 Parameter S, 5, shift-amount width; parameter O, 3, opcode width.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NREQ  per-requester request valid.
REQ-007 req_ready  output  NREQ  per-requester accept, one-hot or zero.
REQ-008 req_data / req_shamt / req_op  input  NREQ*N / NREQ*S / NREQ*O  packed operands, slice i belongs to requester i.
REQ-009 alu_in / alu_shift / alu_op / alu_enable  output  N / S / O / 1  drive to shared shift unit.
REQ-010 alu_result  input  N+1  shift unit registered result, valid the cycle after alu_enable.
REQ-011 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-012 rsp_id / rsp_data / rsp_err  output  clog2(NREQ) / N+1 / 1  requester tag, result, illegal-op flag.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-015 IDLE: if any req_valid, SHALL pick winner round-robin starting at rr_ptr, assert req_ready[winner] for that cycle, latch operands and id, go ISSUE; else stay IDLE.
REQ-016 req_ready SHALL only be asserted in IDLE, at most one bit, and only for a requester with req_valid high.
REQ-017 rr_ptr SHALL become winner+1 modulo NREQ on each grant; wrap from NREQ-1 to 0.
REQ-018 ISSUE: if latched op[2]==0, alu_enable=1 for exactly one cycle with latched operands, go WAIT; if op[2]==1, no alu_enable, rsp_err=1, rsp_data=0, go RESP.
REQ-019 WAIT: SHALL capture alu_result into rsp_data, go RESP (grant-to-rsp_valid latency 3 cycles).
REQ-020 RESP: rsp_valid=1 with stable rsp_id/rsp_data/rsp_err until rsp_ready; on rsp_valid&&rsp_ready go IDLE.
REQ-021 rsp_ready high on entry to RESP SHALL complete in that same cycle; next grant earliest the following cycle.
REQ-022 alu_in/alu_shift/alu_op SHALL hold the latched request in all states (no glitch to 0 between ops).
REQ-023 Requester deasserting req_valid before grant SHALL lose no state and cause no grant.
REQ-024 Sustained back-to-back traffic: all NREQ requesters valid SHALL be served in strict rotation, no starvation beyond NREQ-1 intervening grants.

Reset
REQ-025 On reset SHALL go IDLE; rr_ptr=0; req_ready=0; alu_enable=0; alu_in/alu_shift/alu_op=0; rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0; busy=0.
REQ-026 Reset mid-operation (ISSUE/WAIT/RESP) SHALL abandon the transaction; no response delivered afterwards.
REQ-027 Reset dominates all other inputs in the same cycle.

Structure
REQ-028 Shared package SHALL hold N, S, O, the shift opcode constants (SHLEFTLOG 000, SHLEFTART 001, SHRGHTLOG 010, SHRGHTART 011) and the FSM state enum.
REQ-029 Round-robin picker SHALL be one sub-module rr_picker (inputs req vector, ptr; outputs one-hot grant, index, any).

Verification
REQ-030 Single request req0 data=0x0000_0001 shamt=4 op=000 -> rsp_id=0, rsp_data=0x0_0000_0010, rsp_err=0, rsp_valid 3 cycles after grant.
REQ-031 All 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0 ; rr_ptr wraps 3->0.
REQ-032 req2 op=100 -> no alu_enable pulse, rsp_id=2, rsp_err=1, rsp_data=0.
REQ-033 rsp_ready held low 5 cycles -> rsp_valid/rsp_data stable, no req_ready asserted, busy=1 throughout.
REQ-034 Reset asserted in WAIT -> next cycle IDLE, rsp_valid=0, rr_ptr=0; subsequent request served normally.
REQ-035 req1 data=0x8000_0000 shamt=31 op=011 with unit model -> rsp_data equals model output captured exactly one cycle after alu_enable.
